// File: rtl/jtpopeye_dma_sched.sv
// jtpopeye_dma_sched
//   Once per frame, on the rising edge of vertical blank, this block asks the
//   Z80 for its bus and copies LEN+1 bytes from CPU RAM into object RAM. It then
//   hands the bus back. All state advances on pxl_cen. The bus acknowledge is
//   sampled only on ticks where cpu_cen is also high.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   pxl_cen, cpu_cen  pixel / CPU clock enables
//   VB                vertical blank
//   busak_n           Z80 bus acknowledge (active-low)
//   DD                CPU RAM read data
//   busrq_n           Z80 bus request (active-low)
//   AD, dma_cs        CPU RAM read address and DMA-owned chip select
//   obj_addr/_data/_we object RAM write port; the strobe is one clk wide
//   busy              high in any state other than IDLE
//   done, abort       one-clk pulses: transfer finished / transfer abandoned
//   dbg_state         current FSM state, for observation only
//
// Handshake: the bus is ours from the first cpu_cen tick that sees busak_n low
// while busrq_n is low. It is given back by raising busrq_n. We do not return
// to IDLE until a cpu_cen tick sees busak_n high again.
module jtpopeye_dma_sched #(
  parameter int          AW   = 10,
  parameter int unsigned LEN  = 10'h3FF,
  parameter logic [15:0] TOUT = 16'd512
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pxl_cen,
  input  logic          cpu_cen,
  input  logic          VB,
  input  logic          busak_n,
  input  logic [7:0]    DD,
  output logic          busrq_n,
  output logic [AW-1:0] AD,
  output logic          dma_cs,
  output logic [AW-1:0] obj_addr,
  output logic [7:0]    obj_data,
  output logic          obj_we,
  output logic          busy,
  output logic          done,
  output logic          abort,
  output logic [1:0]    dbg_state
);

  localparam logic [AW-1:0] LAST = AW'(LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    XFER = 2'd2,
    REL  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic          vb_l, vb_l_nx;
  // armed stays low until the first pxl_cen after reset. This means a VB that
  // is already high when reset is released is not seen as a rising edge.
  logic          armed, armed_nx;
  logic [15:0]   tout, tout_nx;
  logic          phase, phase_nx;
  logic          busrq_nx, dma_cs_nx, we_nx, done_nx, abort_nx;
  logic [AW-1:0] ad_nx, oaddr_nx;
  logic [7:0]    odata_nx;
  logic          vb_rise;

  assign vb_rise   = VB & ~vb_l & armed;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      vb_l     <= 1'b0;
      armed    <= 1'b0;
      tout     <= '0;
      phase    <= 1'b0;
      busrq_n  <= 1'b1;
      dma_cs   <= 1'b0;
      AD       <= '0;
      obj_addr <= '0;
      obj_data <= '0;
      obj_we   <= 1'b0;
      done     <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state    <= state_nx;
      vb_l     <= vb_l_nx;
      armed    <= armed_nx;
      tout     <= tout_nx;
      phase    <= phase_nx;
      busrq_n  <= busrq_nx;
      dma_cs   <= dma_cs_nx;
      AD       <= ad_nx;
      obj_addr <= oaddr_nx;
      obj_data <= odata_nx;
      obj_we   <= we_nx;
      done     <= done_nx;
      abort    <= abort_nx;
    end
  end

  always_comb begin
    // Pulse outputs default low, so each pulse lasts exactly one clk.
    state_nx  = state;
    vb_l_nx   = vb_l;
    armed_nx  = armed;
    tout_nx   = tout;
    phase_nx  = phase;
    busrq_nx  = busrq_n;
    dma_cs_nx = dma_cs;
    ad_nx     = AD;
    oaddr_nx  = obj_addr;
    odata_nx  = obj_data;
    we_nx     = 1'b0;
    done_nx   = 1'b0;
    abort_nx  = 1'b0;
    if (pxl_cen) begin
      vb_l_nx  = VB;
      armed_nx = 1'b1;
      case (state)
        IDLE: begin
          if (vb_rise) begin
            state_nx = REQ;
            busrq_nx = 1'b0;
            tout_nx  = '0;
          end
        end
        REQ: begin
          // Losing VB or running out of time takes priority over an ack
          // that arrives on the same tick.
          if (!VB || tout == TOUT) begin
            state_nx  = REL;
            abort_nx  = 1'b1;
            busrq_nx  = 1'b1;
            dma_cs_nx = 1'b0;
          end else if (cpu_cen && !busak_n) begin
            state_nx  = XFER;
            dma_cs_nx = 1'b1;
            ad_nx     = '0;
            phase_nx  = 1'b0;
          end else begin
            tout_nx = tout + 16'd1;
          end
        end
        XFER: begin
          if (!VB) begin
            state_nx  = REL;
            abort_nx  = 1'b1;
            busrq_nx  = 1'b1;
            dma_cs_nx = 1'b0;
          end else if (!phase) begin
            // Phase 0 gives the RAM one tick with AD held steady.
            phase_nx = 1'b1;
          end else begin
            oaddr_nx = AD;
            odata_nx = DD;
            we_nx    = 1'b1;
            if (AD == LAST) begin
              state_nx  = REL;
              done_nx   = 1'b1;
              busrq_nx  = 1'b1;
              dma_cs_nx = 1'b0;
            end else begin
              ad_nx    = AD + 1'b1;
              phase_nx = 1'b0;
            end
          end
        end
        REL: begin
          busrq_nx  = 1'b1;
          dma_cs_nx = 1'b0;
          if (cpu_cen && busak_n) state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule
